// File: rtl/data_memory_responder.sv
// Multi-cycle doubleword RAM responder for the MEM-stage data port.
// It holds the pipeline in stall while an access is in flight and pulses done when the access completes.
module data_memory_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [63:0] address,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        stall,
    output logic        done,
    output logic        error
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'd8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_read_q, op_read_d;
    logic               op_write_q, op_write_d;
    logic               err_q, err_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [63:0]        wdata_q, wdata_d;
    logic [63:0]        read_data_q, read_data_d;
    logic               done_q, done_d;
    logic               error_q, error_d;

    logic [63:0]        mem [DEPTH];

    logic               req_s;
    logic               misaligned_s;
    logic               out_of_range_s;
    logic               illegal_s;
    logic               access_s;
    logic               mem_we_s;

    assign req_s          = mem_read | mem_write;
    assign misaligned_s   = |address[2:0];
    assign out_of_range_s = (address >= ADDR_LIMIT);
    assign illegal_s      = mem_read & mem_write;
    assign access_s       = (state_q == BUSY) && (cnt_q == CNT_W'(0));
    // Reset on the commit edge wins, so an uncommitted write is dropped.
    assign mem_we_s       = reset_n & access_s & op_write_q & ~err_q;

    // Next-state and datapath logic for the IDLE/BUSY/RESP sequencer.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_read_d   = op_read_q;
        op_write_d  = op_write_q;
        err_d       = err_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        read_data_d = read_data_q;
        done_d      = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    op_read_d  = mem_read;
                    op_write_d = mem_write;
                    err_d      = misaligned_s | out_of_range_s | illegal_s;
                    idx_d      = address[3 +: IDX_W];
                    wdata_d    = write_data;
                    cnt_d      = CNT_W'(LATENCY - 1);
                    state_d    = BUSY;
                end else begin
                    state_d    = IDLE;
                end
            end
            BUSY: begin
                if (cnt_q != CNT_W'(0)) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                    done_d  = 1'b1;
                    error_d = err_q;
                    // An illegal read+write also carries op_read, so it returns zero.
                    if (op_read_q) begin
                        read_data_d = err_q ? 64'd0 : mem[idx_q];
                    end else begin
                        read_data_d = read_data_q;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state and registered outputs, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= CNT_W'(0);
            op_read_q   <= 1'b0;
            op_write_q  <= 1'b0;
            err_q       <= 1'b0;
            idx_q       <= IDX_W'(0);
            wdata_q     <= 64'd0;
            read_data_q <= 64'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_read_q   <= op_read_d;
            op_write_q  <= op_write_d;
            err_q       <= err_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            read_data_q <= read_data_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    // Storage array write port; contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (mem_we_s) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign stall     = ((state_q == IDLE) & req_s) | (state_q == BUSY);
    assign read_data = read_data_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder: expected responses are queued at request time
// and compared when done pulses.
module tb_data_memory_responder;

    localparam int DEPTH   = 256;
    localparam int LATENCY = 2;
    localparam int IDX_W   = $clog2(DEPTH);

    logic        clock = 1'b0;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] address;
    logic [63:0] write_data;
    logic [63:0] read_data;
    logic        stall;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [63:0] model_mem [DEPTH];
    logic [63:0] last_rdata = 64'd0;
    logic        exp_err_qu [$];
    logic [63:0] exp_rd_qu [$];
    logic        prev_done = 1'b0;

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .stall      (stall),
        .done       (done),
        .error      (error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: update model state and queue the expected response.
    task automatic predict(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] data);
        logic e;
        logic [IDX_W-1:0] ix;
        e  = (addr[2:0] != 3'd0) || (addr >= 64'(DEPTH * 8)) || (rd && wr);
        ix = addr[3 +: IDX_W];
        if (rd) last_rdata = e ? 64'd0 : model_mem[ix];
        else if (!e) model_mem[ix] = data;
        exp_err_qu.push_back(e);
        exp_rd_qu.push_back(last_rdata);
    endtask

    // Response monitor on the falling edge.
    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            if (done) begin
                if (exp_err_qu.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    chk("resp_error", 64'(error), 64'(exp_err_qu.pop_front()));
                    chk("resp_rdata", read_data, exp_rd_qu.pop_front());
                end
                if (prev_done) chk("done_twice", 64'(prev_done & done), 64'd0);
            end else if (error) begin
                chk("error_without_done", 64'(error), 64'd0);
            end
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic access(input logic rd, input logic wr, input logic [63:0] addr, input logic [63:0] data);
        int lat;
        predict(rd, wr, addr, data);
        @(negedge clock);
        mem_read = rd; mem_write = wr; address = addr; write_data = data;
        #1 chk("stall_accept", 64'(stall), 64'd1);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
            if (!done) chk("stall_busy", 64'(stall), 64'd1);
        end while (!done && lat < 20);
        chk("latency", 64'(lat), 64'(LATENCY + 1));
        chk("stall_resp", 64'(stall), 64'd0);
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clock); #1;
    endtask

    initial begin
        int d [3];
        int n;
        logic [63:0] a;
        reset_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        address = 64'd0; write_data = 64'd0;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_rdata", read_data, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_stall", 64'(stall), 64'd0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        access(1'b0, 1'b1, 64'h40, 64'hDEADBEEF_CAFEF00D);
        access(1'b1, 1'b0, 64'h40, 64'd0);
        access(1'b0, 1'b1, 64'h43, 64'h1);
        access(1'b1, 1'b0, 64'h40, 64'd0);
        access(1'b1, 1'b0, 64'h44, 64'd0);
        access(1'b0, 1'b1, 64'h0, 64'h1111_2222_3333_4444);
        access(1'b1, 1'b0, 64'h40, 64'd0);
        access(1'b1, 1'b0, 64'h800, 64'd0);
        access(1'b0, 1'b1, 64'h800, 64'h5555_5555_5555_5555);
        access(1'b1, 1'b0, 64'h0, 64'd0);
        access(1'b0, 1'b1, 64'h8, 64'h0123_4567_89AB_CDEF);
        access(1'b1, 1'b1, 64'h8, 64'hFFFF_FFFF_FFFF_FFFF);
        access(1'b1, 1'b0, 64'h8, 64'd0);
        access(1'b0, 1'b1, 64'h10, 64'hAAAA_0000_AAAA_0000);

        // Abort a write to 0x10 with reset while it is in BUSY.
        @(negedge clock);
        mem_write = 1'b1; address = 64'h10; write_data = 64'hBBBB_1111_BBBB_1111;
        @(posedge clock); #1;
        chk("abort_busy_stall", 64'(stall), 64'd1);
        reset_n = 1'b0;
        mem_write = 1'b0;
        @(posedge clock); #1;
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_stall", 64'(stall), 64'd0);
        chk("abort_rdata", read_data, 64'd0);
        reset_n = 1'b1;
        last_rdata = 64'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            chk("abort_no_done", 64'(done), 64'd0);
        end
        access(1'b1, 1'b0, 64'h10, 64'd0);

        // Back-to-back reads with the request held high.
        for (int i = 0; i < 3; i++) predict(1'b1, 1'b0, 64'h40, 64'd0);
        @(negedge clock);
        mem_read = 1'b1; address = 64'h40;
        n = 0;
        for (int cyc = 1; cyc <= 40 && n < 3; cyc++) begin
            @(posedge clock); #1;
            if (done) begin
                d[n] = cyc;
                n++;
                if (n == 3) mem_read = 1'b0;
            end
        end
        chk("b2b_count", 64'(n), 64'd3);
        chk("b2b_first", 64'(d[0]), 64'(LATENCY + 1));
        chk("b2b_gap1", 64'(d[1] - d[0]), 64'(LATENCY + 2));
        chk("b2b_gap2", 64'(d[2] - d[1]), 64'(LATENCY + 2));
        mem_read = 1'b0;
        @(posedge clock); #1;

        // Random aligned in-range traffic: write first, then read it back.
        for (int i = 0; i < 6; i++) begin
            a = 64'($urandom_range(0, DEPTH - 1)) << 3;
            access(1'b0, 1'b1, a, {$urandom, $urandom});
            access(1'b1, 1'b0, a, 64'd0);
        end

        repeat (2) @(posedge clock);
        chk("queue_empty", 64'(exp_err_qu.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
